seq_detect_arbiter: RTL and testbench
=====================================

# seq_detect_arbiter

Shares a single "1001" Mealy sequence-detect datapath across `N_CH` independent serial channels. Each channel keeps its own 2-bit detector state and a 1-deep input bit buffer. A round-robin scheduler grants one pending channel per cycle, runs that channel's next bit through the shared transition logic and writes the state back. It sits between the serial front-ends and the match-handling logic, replacing one detector instance per channel.

## Interface

- `N_CH`, default 4: number of channels; power of two, 2..8.
- `CHW`, default 2: log2(`N_CH`); width of channel index.
- `CNT_W`, default 8: width of per-channel match counters (`MATCH_COUNT_EN` only).

Ports:

- `clock` in, 1: single system clock; all state updates on the rising edge.
- `reset` in, 1: asynchronous, active-high; clears all state immediately.
- `bit_in` in, `N_CH`: serial data bit per channel.
- `bit_valid` in, `N_CH`: per-channel strobe; bit is captured on the edge where it is high.
- `buf_full` out, `N_CH`: per-channel buffer holds an unserviced bit (registered).
- `z` out, 1: one-cycle match pulse (registered).
- `z_chan` out, `CHW`: channel that produced `z`; valid only while `z`=1, holds last value otherwise.
- `overflow` out, `N_CH`: sticky per-channel lost-bit flag.
- `clr_ovf` in, 1: clears all `overflow` bits on the next edge.
- `cnt_sel` in, `CHW`: counter read select (`MATCH_COUNT_EN` only).
- `cnt_out` out, `CNT_W`: combinational read of selected channel's counter (`MATCH_COUNT_EN` only).

## Operation

- Per-channel detector states: A=00 (idle), B=01 (saw 1), C=10 (saw 10), D=11 (saw 100).
- Transitions on a serviced bit: A: 1→B, 0→A. B: 1→B, 0→C. C: 1→B, 0→D. D: 1→B with match, 0→A. Overlapping detection: the trailing 1 of a match starts the next sequence.
- Capture: `bit_valid[i]`=1 at an edge writes `bit_in[i]` into buffer i and sets `buf_full[i]`.
- Grant: combinational round-robin over channels with `buf_full`=1. Search starts at `rr_ptr`. At most one grant per cycle.
- Service edge for granted channel g:
  - update `state[g]`
  - clear `buf_full[g]` unless refilled on the same edge
  - `rr_ptr` ← g+1 mod `N_CH`
  - register `z` = match, `z_chan` = g
- No grant in a cycle: `z` ← 0 at the next edge; `rr_ptr` unchanged.
- Simultaneous capture and service on the same channel: the serviced bit is consumed, the new bit is stored, `buf_full` stays 1, no overflow.
- Overflow: `bit_valid[i]`=1 while `buf_full[i]`=1 and channel i is not granted that cycle:
  - incoming bit is dropped; buffered bit is kept
  - `overflow[i]` ← 1
  - a set event on the same edge as `clr_ovf` wins (bit ends at 1)
- Reset (asynchronous, also mid-sequence): all states ← A, `buf_full` ← 0, `rr_ptr` ← 0, `z` ← 0, `z_chan` ← 0, `overflow` ← 0, counters ← 0. Partial sequences are discarded.

## Timing

- Bit captured at edge E0. Earliest service is at edge E1. `z` is high in the cycle after E1, so minimum latency is 2 edges from capture.
- A channel served alone sustains one bit per cycle.
- With all `N_CH` channels loaded, each channel is serviced once every `N_CH` cycles. Worst-case wait from capture to service is `N_CH` edges.
- `buf_full` is registered; producers may use `~buf_full[i]` as a ready signal.
- `z` is never high for two consecutive cycles with the same `z_chan` unless that channel truly matched twice; a minimum of 3 bits separates two matches.

## Configuration

- `SEQ_DETECT_MATCH_COUNT_EN` defined:
  - adds `N_CH` counters of `CNT_W` bits, one per channel
  - a counter increments on each match of its channel and saturates at all-ones
  - adds ports `cnt_sel` and `cnt_out`
  - counters are cleared only by `reset`
- Not defined: counters, `cnt_sel` and `cnt_out` are absent. All other behaviour is identical.

## Test plan

- Ch0 stream 1,0,0,1,0,0,1, one bit per cycle, other channels idle → `z`=1 twice, `z_chan`=0, each pulse 2 cycles after the final 1 is captured; `overflow`=0.
- All 4 channels `bit_valid`=1 in the same cycle with `rr_ptr`=0 → services on 4 consecutive edges in order 0,1,2,3; `rr_ptr` returns to 0; `buf_full` bits clear in that order.
- Ch2 receives a new bit every cycle while being granted every cycle → no overflow, `buf_full[2]` stays 1, detection matches the stream exactly.
- All 4 channels stream every cycle → `overflow` sets on each channel at its first blocked repeat; dropped bits do not reach the detector. Asserting `clr_ovf` alone then clears all bits.
- Ch1 fed 1,0,0, then `reset` pulsed asynchronously mid-cycle, then 1 → no `z`, and all outputs read their reset values during reset.
- With `SEQ_DETECT_MATCH_COUNT_EN` and `CNT_W`=8: 300 matches on ch3 → `cnt_out` with `cnt_sel`=3 reads 255; ch0 counter reads 0.

Source files
------------

// File: rtl/seq_detect_arbiter.sv
// One shared "1001" Mealy detector, time-multiplexed round-robin over N_CH serial channels.
// Optional per-channel saturating match counters: define SEQ_DETECT_MATCH_COUNT_EN.
module seq_detect_arbiter #(
    parameter int N_CH  = 4,
    parameter int CHW   = 2,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_CH-1:0]  bit_in,
    input  logic [N_CH-1:0]  bit_valid,
    output logic [N_CH-1:0]  buf_full,
    output logic             z,
    output logic [CHW-1:0]   z_chan,
    output logic [N_CH-1:0]  overflow,
    input  logic             clr_ovf
`ifdef SEQ_DETECT_MATCH_COUNT_EN
    ,
    input  logic [CHW-1:0]   cnt_sel,
    output logic [CNT_W-1:0] cnt_out
`endif
);

    typedef enum logic [1:0] {
        ST_A = 2'b00,   // idle
        ST_B = 2'b01,   // saw 1
        ST_C = 2'b10,   // saw 10
        ST_D = 2'b11    // saw 100
    } det_state_e;

    det_state_e        state_q [N_CH];
    logic [N_CH-1:0]   buf_bit_q,  buf_bit_d;
    logic [N_CH-1:0]   buf_full_q, buf_full_d;
    logic [N_CH-1:0]   overflow_q, overflow_d;
    logic [CHW-1:0]    rr_ptr_q,   rr_ptr_d;
    logic              z_q,        z_d;
    logic [CHW-1:0]    z_chan_q,   z_chan_d;

    logic              grant_vld;
    logic [CHW-1:0]    grant_idx;
    logic [N_CH-1:0]   grant_oh;
    det_state_e        nxt_state;
    logic              match;

    // Round-robin search starting at rr_ptr; N_CH is a power of two so the index wraps for free.
    always_comb begin
        logic [CHW-1:0] idx;
        grant_vld = 1'b0;
        grant_idx = rr_ptr_q;
        for (int k = 0; k < N_CH; k++) begin
            idx = rr_ptr_q + CHW'(k);
            if (!grant_vld && buf_full_q[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            grant_oh[i] = grant_vld && (grant_idx == CHW'(i));
        end
    end

    // Shared transition logic, applied to the granted channel's state and buffered bit.
    always_comb begin
        logic b;
        b         = buf_bit_q[grant_idx];
        match     = 1'b0;
        nxt_state = ST_A;
        case (state_q[grant_idx])
            ST_A:    nxt_state = b ? ST_B : ST_A;
            ST_B:    nxt_state = b ? ST_B : ST_C;
            ST_C:    nxt_state = b ? ST_B : ST_D;
            ST_D: begin
                nxt_state = b ? ST_B : ST_A;
                match     = b;
            end
            default: nxt_state = ST_A;
        endcase
    end

    // A granted channel's buffer is free this edge, so a same-edge capture refills it without loss.
    always_comb begin
        buf_full_d = buf_full_q;
        buf_bit_d  = buf_bit_q;
        overflow_d = clr_ovf ? '0 : overflow_q;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_oh[i]) begin
                buf_full_d[i] = 1'b0;
            end
            if (bit_valid[i]) begin
                if (!buf_full_q[i] || grant_oh[i]) begin
                    buf_bit_d[i]  = bit_in[i];
                    buf_full_d[i] = 1'b1;
                end else begin
                    overflow_d[i] = 1'b1;
                end
            end
        end
        rr_ptr_d = grant_vld ? grant_idx + CHW'(1) : rr_ptr_q;
        z_d      = grant_vld && match;
        z_chan_d = grant_vld ? grant_idx : z_chan_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the per-channel state and buffer arrays are reset too, so a partial sequence never survives reset.
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_A;
            end
            buf_bit_q  <= '0;
            buf_full_q <= '0;
            overflow_q <= '0;
            rr_ptr_q   <= '0;
            z_q        <= 1'b0;
            z_chan_q   <= '0;
        end else begin
            if (grant_vld) begin
                state_q[grant_idx] <= nxt_state;
            end
            buf_bit_q  <= buf_bit_d;
            buf_full_q <= buf_full_d;
            overflow_q <= overflow_d;
            rr_ptr_q   <= rr_ptr_d;
            z_q        <= z_d;
            z_chan_q   <= z_chan_d;
        end
    end

    assign buf_full = buf_full_q;
    assign overflow = overflow_q;
    assign z        = z_q;
    assign z_chan   = z_chan_q;

`ifdef SEQ_DETECT_MATCH_COUNT_EN
    logic [CNT_W-1:0] cnt_q [N_CH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (z_d && (cnt_q[grant_idx] != '1)) begin
            cnt_q[grant_idx] <= cnt_q[grant_idx] + CNT_W'(1);
        end
    end

    assign cnt_out = cnt_q[cnt_sel];
`endif

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Directed bench for seq_detect_arbiter: a queue/window-level model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_seq_detect_arbiter;

    localparam int N_CH    = 4;
    localparam int CHW     = 2;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [N_CH-1:0]  bit_in = '0;
    logic [N_CH-1:0]  bit_valid = '0;
    logic             clr_ovf = 1'b0;
    logic [N_CH-1:0]  buf_full;
    logic             z;
    logic [CHW-1:0]   z_chan;
    logic [N_CH-1:0]  overflow;
`ifdef SEQ_DETECT_MATCH_COUNT_EN
    logic [CHW-1:0]   cnt_sel = '0;
    logic [CNT_W-1:0] cnt_out;
`endif

    int n_vec = 0;
    int n_err = 0;
    int z_seen;

    seq_detect_arbiter #(.N_CH(N_CH), .CHW(CHW), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .buf_full  (buf_full),
        .z         (z),
        .z_chan    (z_chan),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
`ifdef SEQ_DETECT_MATCH_COUNT_EN
        ,
        .cnt_sel   (cnt_sel),
        .cnt_out   (cnt_out)
`endif
    );

    always #5 clock = ~clock;

    // Model: each channel is a one-slot mailbox plus a window of the last four serviced bits;
    // a match is simply "window == 1001".
    logic [N_CH-1:0] m_full, m_bit, m_ovf;
    logic [3:0]      m_hist [N_CH];
    int              m_cnt  [N_CH];
    int              m_ptr;
    logic            m_z;
    logic [CHW-1:0]  m_zc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_full = '0;
        m_bit  = '0;
        m_ovf  = '0;
        m_ptr  = 0;
        m_z    = 1'b0;
        m_zc   = '0;
        for (int i = 0; i < N_CH; i++) begin
            m_hist[i] = '0;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic model_step(input logic [N_CH-1:0] v, input logic [N_CH-1:0] b, input logic c);
        int g;
        int ch;
        logic [3:0] h;
        g = -1;
        for (int k = 0; k < N_CH; k++) begin
            ch = (m_ptr + k) % N_CH;
            if (g < 0 && m_full[ch]) g = ch;
        end
        if (g >= 0) begin
            h         = {m_hist[g][2:0], m_bit[g]};
            m_hist[g] = h;
            m_z       = (h == 4'b1001);
            m_zc      = CHW'(g);
            m_full[g] = 1'b0;
            m_ptr     = (g + 1) % N_CH;
            if (m_z && m_cnt[g] < CNT_MAX) m_cnt[g]++;
        end else begin
            m_z = 1'b0;
        end
        if (c) m_ovf = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (v[i]) begin
                if (m_full[i]) m_ovf[i] = 1'b1;
                else begin
                    m_bit[i]  = b[i];
                    m_full[i] = 1'b1;
                end
            end
        end
    endtask

    // Compare process: outputs against the model on every falling edge outside reset.
    always @(negedge clock) begin
        if (!reset) begin
            check("buf_full", 32'(buf_full), 32'(m_full));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("z",        32'(z),        32'(m_z));
            check("z_chan",   32'(z_chan),   32'(m_zc));
        end
    end

    // One clock cycle: drive inputs at the falling edge, step the model at the rising edge.
    task automatic tick(input logic [N_CH-1:0] v, input logic [N_CH-1:0] b, input logic c);
        bit_valid = v;
        bit_in    = b;
        clr_ovf   = c;
        @(posedge clock);
        model_step(v, b, c);
        @(negedge clock);
        bit_valid = '0;
        bit_in    = '0;
        clr_ovf   = 1'b0;
        if (z) z_seen++;
    endtask

    // Asynchronous reset pulse in the middle of the low phase; outputs checked while it is held.
    task automatic do_reset();
        bit_valid = '0;
        clr_ovf   = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_buf_full", 32'(buf_full), 32'h0);
        check("rst_z",        32'(z),        32'h0);
        check("rst_z_chan",   32'(z_chan),   32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        model_reset();
        #1 reset = 1'b0;
    endtask

    logic [6:0]  s1 = 7'b1001001;                 // sent MSB first
    logic [10:0] s3 = 11'b10010011001;            // sent MSB first
    logic [3:0]  t4 [8] = '{4'hA, 4'h5, 4'h3, 4'hC, 4'h9, 4'h6, 4'hF, 4'h0};
    logic [7:0]  z_exp1 = 8'b00001001;            // z after ticks 1..8, tick 1 in the MSB
    logic [3:0]  bf_exp2 [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};

    initial begin
        model_reset();
        #5;

        // Ch0 stream 1001001: pulses 2 edges after each final 1 is captured.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if (k < 7) tick(4'b0001, {3'b000, s1[6-k]}, 1'b0);
            else       tick(4'b0000, 4'b0000, 1'b0);
            check("t1_z_literal", 32'(z), 32'(z_exp1[7-k]));
            if (z) check("t1_zchan_literal", 32'(z_chan), 32'h0);
        end
        check("t1_overflow_literal", 32'(overflow), 32'h0);

        // All channels loaded at once from rr_ptr=0: served 0,1,2,3 then pointer back at 0.
        do_reset();
        tick(4'b1111, 4'b0000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick(4'b0000, 4'b0000, 1'b0);
            check("t2_order_literal", 32'(z_chan), 32'(k));
            check("t2_buf_full_literal", 32'(buf_full), 32'(bf_exp2[k]));
        end
        tick(4'b1010, 4'b0000, 1'b0);
        tick(4'b0000, 4'b0000, 1'b0);
        check("t2_ptr_wrap_literal", 32'(z_chan), 32'h1);
        tick(4'b0000, 4'b0000, 1'b0);
        check("t2_ptr_next_literal", 32'(z_chan), 32'h3);

        // Ch2 refilled every cycle while granted every cycle: no loss, three matches.
        do_reset();
        z_seen = 0;
        for (int k = 0; k < 11; k++) begin
            tick(4'b0100, {1'b0, s3[10-k], 2'b00}, 1'b0);
        end
        check("t3_buf_full_literal", 32'(buf_full), 32'h4);
        check("t3_overflow_literal", 32'(overflow), 32'h0);
        tick(4'b0000, 4'b0000, 1'b0);
        tick(4'b0000, 4'b0000, 1'b0);
        check("t3_matches_literal", 32'(z_seen), 32'd3);

        // All channels stream every cycle: every channel overflows; set beats clear; clear alone clears.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            tick(4'b1111, t4[k], 1'b0);
        end
        check("t4_overflow_literal", 32'(overflow), 32'hF);
        tick(4'b1111, 4'b1111, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick(4'b0000, 4'b0000, 1'b0);
        end
        tick(4'b0000, 4'b0000, 1'b1);
        check("t4_clear_literal", 32'(overflow), 32'h0);

        // Ch1 fed 100, reset mid-sequence, then 1: the partial sequence is gone.
        do_reset();
        z_seen = 0;
        tick(4'b0010, 4'b0010, 1'b0);
        tick(4'b0010, 4'b0000, 1'b0);
        tick(4'b0010, 4'b0000, 1'b0);
        do_reset();
        tick(4'b0010, 4'b0010, 1'b0);
        tick(4'b0000, 4'b0000, 1'b0);
        tick(4'b0000, 4'b0000, 1'b0);
        check("t5_no_match_literal", 32'(z_seen), 32'd0);

`ifdef SEQ_DETECT_MATCH_COUNT_EN
        // 300 matches on ch3 saturate its counter; ch0 stays at zero.
        do_reset();
        tick(4'b1000, 4'b1000, 1'b0);
        for (int m = 0; m < 300; m++) begin
            tick(4'b1000, 4'b0000, 1'b0);
            tick(4'b1000, 4'b0000, 1'b0);
            tick(4'b1000, 4'b1000, 1'b0);
        end
        tick(4'b0000, 4'b0000, 1'b0);
        tick(4'b0000, 4'b0000, 1'b0);
        cnt_sel = 2'd3;
        #1;
        check("cnt3_saturated_literal", 32'(cnt_out), 32'd255);
        check("cnt3_model", 32'(cnt_out), 32'(m_cnt[3]));
        cnt_sel = 2'd0;
        #1;
        check("cnt0_literal", 32'(cnt_out), 32'd0);
`endif

        tick(4'b0000, 4'b0000, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
